vlsu_axi_rbuf: RTL and testbench

Credit-based AXI read-response buffer between the vector load/store unit's AXI master port and the memory interconnect. AR requests are forwarded only once buffer space for the whole burst is reserved. Every R beat is captured in a local FIFO, so vldu back-pressure never stalls the memory system's R channel. AW, W and B pass through combinationally.

---
 rtl/vlsu_axi_rbuf_pkg.sv | 62 ++++++
 rtl/vlsu_axi_rbuf_fifo.sv | 56 +++++
 rtl/vlsu_axi_rbuf.sv | 116 +++++++++++
 tb/tb_vlsu_axi_rbuf.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_axi_rbuf_pkg.sv
// Shared AXI channel payloads and helpers for the vlsu R-response buffer.
package vlsu_axi_rbuf_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;
  localparam int unsigned LenWidth  = 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vlsu_axi_rbuf_fifo.sv
// Registered (non fall-through) FIFO holding buffered R beats.
module vlsu_axi_rbuf_fifo #(
  parameter type         dtype        = logic,
  parameter int unsigned DEPTH        = 16,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  dtype                         data_i,
  input  logic                         pop_i,
  output dtype                         data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH+1);

  if (FALL_THROUGH) begin : g_bad_mode
    $error("vlsu_axi_rbuf_fifo supports only FALL_THROUGH = 0");
  end

  dtype            mem [DEPTH];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic            do_push, do_pop;

  assign full_o  = (count == CntW'(DEPTH));
  assign empty_o = (count == '0);
  assign usage_o = count;
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PtrW'(DEPTH-1)) ? '0 : wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(DEPTH-1)) ? '0 : rd_ptr + PtrW'(1);
      if (do_push && !do_pop)      count <= count + CntW'(1);
      else if (do_pop && !do_push) count <= count - CntW'(1);
    end
  end

  // Beat storage; contents need no reset since validity follows count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/vlsu_axi_rbuf.sv
// Credit-based AXI read-response buffer: ARs go out only with room reserved
// for the whole burst, so the memory R channel is never back-pressured.
module vlsu_axi_rbuf
  import vlsu_axi_rbuf_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 0,
  parameter int unsigned AxiAddrWidth = 0,
  parameter type         axi_r_t      = r_chan_t,
  parameter type         axi_req_t    = req_t,
  parameter type         axi_resp_t   = resp_t,
  parameter int unsigned BufDepth     = 16,
  parameter int unsigned MaxBeats     = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  axi_req_t                        slv_req_i,
  output axi_resp_t                       slv_resp_o,
  output axi_req_t                        mst_req_o,
  input  axi_resp_t                       mst_resp_i,
  output logic [$clog2(BufDepth+1)-1:0]   rbuf_credits_o,
  output logic                            rbuf_error_o
);

  localparam int unsigned CW    = $clog2(BufDepth+1);
  localparam int unsigned SW    = CW + 1;
  localparam int unsigned NeedW = max_u(CW + 1, LenWidth + 1);

  if (AxiDataWidth == 0 || AxiAddrWidth == 0) begin : g_bad_width
    $error("vlsu_axi_rbuf: AxiDataWidth and AxiAddrWidth must be nonzero");
  end
  if (BufDepth < 1) begin : g_bad_depth
    $error("vlsu_axi_rbuf: BufDepth must be at least 1");
  end
  if (MaxBeats > BufDepth) begin : g_bad_beats
    $error("vlsu_axi_rbuf: MaxBeats must not exceed BufDepth");
  end

  logic [CW-1:0]    credits_q, credits_d, occupancy;
  logic [SW-1:0]    credit_sum;
  logic [NeedW-1:0] need;
  logic             ar_ok, ar_hs, r_push, r_pop, unreserved;
  logic             fifo_full, fifo_empty;
  logic             err_q, err_d;
  axi_r_t           fifo_head;

  // Burst size and gate against the registered credit count.
  always_comb begin
    need  = NeedW'(slv_req_i.ar.len) + NeedW'(1);
    ar_ok = (need <= NeedW'(credits_q));
  end

  // Channel wiring: AW/W/B straight through, AR gated, R served from the FIFO.
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_ok;
    mst_req_o.r_ready   = ~fifo_full;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
    slv_resp_o.r_valid  = ~fifo_empty;
    slv_resp_o.r        = fifo_head;
  end

  assign ar_hs  = slv_req_i.ar_valid & ar_ok & mst_resp_i.ar_ready;
  assign r_push = mst_resp_i.r_valid & ~fifo_full;
  assign r_pop  = slv_req_i.r_ready & ~fifo_empty;

  // Net credit change; a release for an unreserved beat is clipped at depth.
  always_comb begin
    credit_sum = SW'(credits_q) - (ar_hs ? SW'(need) : '0) + SW'(r_pop);
    credits_d  = (credit_sum > SW'(BufDepth)) ? CW'(BufDepth) : CW'(credit_sum);
  end

  // Sticky error: oversize AR, or a beat arriving with nothing reserved.
  always_comb begin
    unreserved = ((SW'(occupancy) + SW'(credits_q)) == SW'(BufDepth));
    err_d      = err_q
               | (slv_req_i.ar_valid & (need > NeedW'(MaxBeats)))
               | (r_push & unreserved);
  end

  // Credit and error state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q <= CW'(BufDepth);
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // Credits can never exceed the buffer depth.
  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (credits_q <= CW'(BufDepth));
  end

  assign rbuf_credits_o = credits_q;
  assign rbuf_error_o   = err_q;

  vlsu_axi_rbuf_fifo #(
    .dtype       (axi_r_t),
    .DEPTH       (BufDepth),
    .FALL_THROUGH(1'b0)
  ) i_r_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (r_push),
    .data_i (mst_resp_i.r),
    .pop_i  (r_pop),
    .data_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .usage_o(occupancy)
  );

endmodule

// File: tb/tb_vlsu_axi_rbuf.sv
// Directed bench for vlsu_axi_rbuf: credits, gating, buffering, error flag, passthrough.
module tb_vlsu_axi_rbuf;
  import vlsu_axi_rbuf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  req_t       req;
  resp_t      sresp;
  req_t       mreq;
  resp_t      mresp;
  logic [4:0] credits;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vlsu_axi_rbuf #(
    .AxiDataWidth(32),
    .AxiAddrWidth(32),
    .BufDepth    (16),
    .MaxBeats    (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .slv_req_i     (req),
    .slv_resp_o    (sresp),
    .mst_req_o     (mreq),
    .mst_resp_i    (mresp),
    .rbuf_credits_o(credits),
    .rbuf_error_o  (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req   = '0;
    mresp = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_credits", 128'(credits), 128'(16));
    chk("rst_r_valid", 128'(sresp.r_valid), 128'(0));
    chk("rst_r_ready", 128'(mreq.r_ready), 128'(1));
    chk("rst_error", 128'(err), 128'(0));

    // Single burst of 8 beats, buffered then drained
    req.ar.len = 8'd7; req.ar.addr = 32'h1000; req.ar_valid = 1'b1; mresp.ar_ready = 1'b1;
    #1;
    chk("sb_ar_valid", 128'(mreq.ar_valid), 128'(1));
    chk("sb_ar_ready", 128'(sresp.ar_ready), 128'(1));
    chk("sb_ar_fwd", 128'(mreq.ar), 128'(req.ar));
    tick();
    req.ar_valid = 1'b0; mresp.ar_ready = 1'b0;
    chk("sb_credits_res", 128'(credits), 128'(8));
    for (int i = 0; i < 8; i++) begin
      mresp.r_valid = 1'b1; mresp.r.data = 32'(100 + i); mresp.r.last = (i == 7);
      tick();
      chk("sb_buffered_valid", 128'(sresp.r_valid), 128'(1));
    end
    mresp.r_valid = 1'b0;
    chk("sb_credits_held", 128'(credits), 128'(8));
    chk("sb_no_error", 128'(err), 128'(0));
    req.r_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("sb_out_valid", 128'(sresp.r_valid), 128'(1));
      chk("sb_out_data", 128'(sresp.r.data), 128'(100 + i));
      chk("sb_out_last", 128'(sresp.r.last), 128'(i == 7));
      tick();
    end
    req.r_ready = 1'b0;
    chk("sb_empty", 128'(sresp.r_valid), 128'(0));
    chk("sb_credits_back", 128'(credits), 128'(16));

    // Credit starvation
    req.ar.len = 8'd15; req.ar_valid = 1'b1; mresp.ar_ready = 1'b1;
    #1;
    chk("cs_first_fwd", 128'(mreq.ar_valid), 128'(1));
    tick();
    chk("cs_credits_zero", 128'(credits), 128'(0));
    req.ar.len = 8'd0;
    #1;
    chk("cs_held_valid", 128'(mreq.ar_valid), 128'(0));
    chk("cs_held_ready", 128'(sresp.ar_ready), 128'(0));
    for (int i = 0; i < 16; i++) begin
      mresp.r_valid = 1'b1; mresp.r.data = 32'(200 + i); mresp.r.last = (i == 15);
      tick();
    end
    mresp.r_valid = 1'b0;
    #1;
    chk("cs_still_held", 128'(mreq.ar_valid), 128'(0));
    req.r_ready = 1'b1;
    #1;
    chk("cs_pop_head", 128'(sresp.r.data), 128'(200));
    chk("cs_held_pop_cycle", 128'(mreq.ar_valid), 128'(0));
    tick();
    req.r_ready = 1'b0;
    chk("cs_credit_freed", 128'(credits), 128'(1));
    #1;
    chk("cs_second_fwd", 128'(mreq.ar_valid), 128'(1));
    tick();
    req.ar_valid = 1'b0; mresp.ar_ready = 1'b0;
    chk("cs_credits_after", 128'(credits), 128'(0));
    mresp.r_valid = 1'b1; mresp.r.data = 32'd300; mresp.r.last = 1'b1;
    req.r_ready = 1'b1;
    tick();
    mresp.r_valid = 1'b0;
    repeat (15) tick();
    req.r_ready = 1'b0;
    chk("cs_drained", 128'(sresp.r_valid), 128'(0));
    chk("cs_credits_restored", 128'(credits), 128'(16));

    // Simultaneous reserve and release
    req.ar.len = 8'd11; req.ar_valid = 1'b1; mresp.ar_ready = 1'b1;
    tick();
    req.ar_valid = 1'b0; mresp.ar_ready = 1'b0;
    mresp.r_valid = 1'b1; mresp.r.data = 32'd400; mresp.r.last = 1'b0;
    tick();
    mresp.r_valid = 1'b0;
    chk("sim_credits_4", 128'(credits), 128'(4));
    req.r_ready = 1'b1; req.ar.len = 8'd1; req.ar_valid = 1'b1; mresp.ar_ready = 1'b1;
    #1;
    chk("sim_ar_fwd", 128'(mreq.ar_valid), 128'(1));
    tick();
    req.ar_valid = 1'b0; mresp.ar_ready = 1'b0;
    chk("sim_credits_net", 128'(credits), 128'(3));
    for (int i = 0; i < 13; i++) begin
      mresp.r_valid = 1'b1; mresp.r.data = 32'(500 + i); mresp.r.last = (i == 12);
      tick();
    end
    mresp.r_valid = 1'b0;
    tick();
    req.r_ready = 1'b0;
    chk("sim_credits_restored", 128'(credits), 128'(16));
    chk("sim_no_error", 128'(err), 128'(0));

    // Unreserved beat sets the sticky error
    mresp.r_valid = 1'b1; mresp.r.data = 32'hBAD; mresp.r.last = 1'b1;
    tick();
    mresp.r_valid = 1'b0;
    chk("ur_error_set", 128'(err), 128'(1));
    chk("ur_beat_buffered", 128'(sresp.r_valid), 128'(1));
    chk("ur_beat_data", 128'(sresp.r.data), 128'(32'hBAD));
    req.r_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    chk("ur_credits_capped", 128'(credits), 128'(16));
    repeat (3) tick();
    chk("ur_error_sticky", 128'(err), 128'(1));

    // Oversize AR flags an error and stays gated
    rst_n = 1'b0;
    #1;
    chk("os_reset_clears", 128'(err), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    req.ar.len = 8'd20; req.ar_valid = 1'b1; mresp.ar_ready = 1'b1;
    #1;
    chk("os_gated", 128'(mreq.ar_valid), 128'(0));
    tick();
    req.ar_valid = 1'b0; mresp.ar_ready = 1'b0;
    chk("os_error_set", 128'(err), 128'(1));
    chk("os_credits", 128'(credits), 128'(16));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // AW/W/B passthrough with vlsu R back-pressure
    for (int i = 0; i < 24; i++) begin
      req.aw.addr     = $urandom();
      req.aw.id       = 4'($urandom());
      req.aw.len      = 8'($urandom());
      req.aw_valid    = 1'($urandom());
      req.w.data      = $urandom();
      req.w.strb      = 4'($urandom());
      req.w.last      = 1'($urandom());
      req.w_valid     = 1'($urandom());
      req.b_ready     = 1'($urandom());
      req.r_ready     = 1'($urandom());
      mresp.aw_ready  = 1'($urandom());
      mresp.w_ready   = 1'($urandom());
      mresp.b_valid   = 1'($urandom());
      mresp.b.id      = 4'($urandom());
      mresp.b.resp    = 2'($urandom());
      #1;
      chk("pt_aw", 128'(mreq.aw), 128'(req.aw));
      chk("pt_aw_valid", 128'(mreq.aw_valid), 128'(req.aw_valid));
      chk("pt_w", 128'(mreq.w), 128'(req.w));
      chk("pt_w_valid", 128'(mreq.w_valid), 128'(req.w_valid));
      chk("pt_b_ready", 128'(mreq.b_ready), 128'(req.b_ready));
      chk("pt_aw_ready", 128'(sresp.aw_ready), 128'(mresp.aw_ready));
      chk("pt_w_ready", 128'(sresp.w_ready), 128'(mresp.w_ready));
      chk("pt_b_valid", 128'(sresp.b_valid), 128'(mresp.b_valid));
      chk("pt_b", 128'(sresp.b), 128'(mresp.b));
      tick();
    end
    chk("pt_credits", 128'(credits), 128'(16));
    chk("pt_no_error", 128'(err), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
